// File: rtl/fire_control.sv
// fire_control
//   Trigger sequencer ahead of the ammo counter. Converts the pilot trigger
//   level into one-cycle fire strobes (single, burst, auto) with a matching
//   per-shot round count, enforces a cooldown between shots, tracks barrel
//   heat with a hysteretic overheat lockout, and flags illegal trigger pulls.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   mode_selector in   ship mode, 4'b0010 = attack
//   fire_mode     in   00 safe, 01 single, 10 burst, 11 auto
//   trigger       in   pilot trigger level
//   loading       in   reload in progress
//   ammo_count    in   current ammo count (fed back from the counter)
//   fire          out  one-cycle shot strobe
//   fire_rate     out  rounds consumed per shot
//   error         out  one-cycle illegal-pull pulse
//   overheat      out  heat lockout flag
//   heat          out  current barrel heat
module fire_control #(
  parameter int unsigned N             = 9,
  parameter int unsigned BURST_LEN     = 3,
  parameter int unsigned COOLDOWN      = 4,
  parameter int unsigned HEAT_PER_SHOT = 8,
  parameter int unsigned HEAT_MAX      = 200,
  parameter int unsigned HEAT_RESUME   = 100,
  parameter int unsigned RATE_SINGLE   = 1,
  parameter int unsigned RATE_AUTO     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   mode_selector,
  input  logic [1:0]   fire_mode,
  input  logic         trigger,
  input  logic         loading,
  input  logic [N-1:0] ammo_count,
  output logic         fire,
  output logic [N-1:0] fire_rate,
  output logic         error,
  output logic         overheat,
  output logic [7:0]   heat
);

  localparam int unsigned SW = $clog2(BURST_LEN + 1);
  localparam int unsigned GW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [3:0]    MODE_ATTACK = 4'b0010;
  localparam logic [1:0]    FM_SAFE     = 2'b00;
  localparam logic [1:0]    FM_BURST    = 2'b10;
  localparam logic [1:0]    FM_AUTO     = 2'b11;
  localparam logic [SW-1:0] BURST_INIT  = SW'(BURST_LEN);
  localparam logic [GW-1:0] GAP_INIT    = GW'(COOLDOWN - 1);
  localparam logic [N-1:0]  RATE_S      = N'(RATE_SINGLE);
  localparam logic [N-1:0]  RATE_A      = N'(RATE_AUTO);
  localparam logic [8:0]    HEAT_INC    = 9'(HEAT_PER_SHOT);
  localparam logic [7:0]    HEAT_HI     = 8'(HEAT_MAX);
  localparam logic [7:0]    HEAT_LO     = 8'(HEAT_RESUME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          trig_q;
  logic          primed_q;
  logic [SW-1:0] shots_q, shots_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          fire_q, fire_d;
  logic [N-1:0]  rate_q, rate_d;
  logic          error_q, error_d;
  logic          ovh_q, ovh_d;
  logic [7:0]    heat_q, heat_d;

  logic          pull;
  logic          armed;
  logic          is_auto;
  logic          enter_fire;
  logic [8:0]    heat_sum;

  // primed_q masks the first edge after reset so a trigger held through
  // reset is not mistaken for a fresh pull.
  assign pull    = trigger & ~trig_q & primed_q;
  assign is_auto = (fire_mode == FM_AUTO);
  assign armed   = (mode_selector == MODE_ATTACK) & ~loading &
                   (ammo_count != '0) & ~ovh_q & (fire_mode != FM_SAFE);
  assign heat_sum = {1'b0, heat_q} + HEAT_INC;

  always_comb begin
    state_d    = state_q;
    shots_d    = shots_q;
    gap_d      = gap_q;
    rate_d     = rate_q;
    fire_d     = 1'b0;
    error_d    = 1'b0;
    enter_fire = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pull) begin
          if (armed) enter_fire = 1'b1;
          else       error_d    = 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_GAP;
        gap_d   = GAP_INIT;
        shots_d = shots_q - SW'(1);
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (armed && (shots_q != '0 || (is_auto && trigger))) begin
          enter_fire = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Mode is sampled on every entry into FIRE; a burst in progress keeps its
    // remaining count, while auto always reloads a single shot.
    if (enter_fire) begin
      state_d = S_FIRE;
      fire_d  = 1'b1;
      rate_d  = is_auto ? RATE_A : RATE_S;
      if (state_q == S_IDLE) begin
        shots_d = (fire_mode == FM_BURST) ? BURST_INIT : SW'(1);
      end else if (is_auto) begin
        shots_d = SW'(1);
      end
    end
  end

  // Heat follows the registered fire strobe; overheat follows registered heat.
  always_comb begin
    if (fire_q) begin
      heat_d = heat_sum[8] ? 8'hFF : heat_sum[7:0];
    end else if (heat_q != '0) begin
      heat_d = heat_q - 8'd1;
    end else begin
      heat_d = '0;
    end

    ovh_d = ovh_q;
    if (heat_q >= HEAT_HI) begin
      ovh_d = 1'b1;
    end else if (heat_q <= HEAT_LO) begin
      ovh_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      trig_q   <= 1'b0;
      primed_q <= 1'b0;
      shots_q  <= '0;
      gap_q    <= '0;
      fire_q   <= 1'b0;
      rate_q   <= RATE_S;
      error_q  <= 1'b0;
      ovh_q    <= 1'b0;
      heat_q   <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trigger;
      primed_q <= 1'b1;
      shots_q  <= shots_d;
      gap_q    <= gap_d;
      fire_q   <= fire_d;
      rate_q   <= rate_d;
      error_q  <= error_d;
      ovh_q    <= ovh_d;
      heat_q   <= heat_d;
    end
  end

  assign fire      = fire_q;
  assign fire_rate = rate_q;
  assign error     = error_q;
  assign overheat  = ovh_q;
  assign heat      = heat_q;

endmodule

// File: tb/tb_fire_control.sv
`timescale 1ns/1ps
module tb_fire_control;

  localparam int N     = 9;
  localparam int BURST = 3;
  localparam int COOL  = 4;
  localparam int HPS   = 8;
  localparam int HMAX  = 200;
  localparam int HRES  = 100;
  localparam int RS    = 1;
  localparam int RA    = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   mode_selector;
  logic [1:0]   fire_mode;
  logic         trigger;
  logic         loading;
  logic [N-1:0] ammo_count;
  logic         fire;
  logic [N-1:0] fire_rate;
  logic         error;
  logic         overheat;
  logic [7:0]   heat;

  always #5 clk = ~clk;

  fire_control #(
    .N(N), .BURST_LEN(BURST), .COOLDOWN(COOL), .HEAT_PER_SHOT(HPS),
    .HEAT_MAX(HMAX), .HEAT_RESUME(HRES), .RATE_SINGLE(RS), .RATE_AUTO(RA)
  ) dut (
    .clk(clk), .rst(rst), .mode_selector(mode_selector), .fire_mode(fire_mode),
    .trigger(trigger), .loading(loading), .ammo_count(ammo_count),
    .fire(fire), .fire_rate(fire_rate), .error(error), .overheat(overheat), .heat(heat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: shots are scheduled on an absolute edge timeline.
  // m_next is the edge at which the cooldown after the last shot expires
  // (-1 when the trigger logic is free), m_left the shots still owed.
  int m_heat, m_rate, m_next, m_left, m_since_rst, edge_n;
  bit m_ovh, m_fire, m_err, m_prev_trig;

  function automatic void model_reset();
    m_heat = 0; m_rate = RS; m_next = -1; m_left = 0; m_since_rst = 0;
    m_ovh = 0; m_fire = 0; m_err = 0; m_prev_trig = 0;
  endfunction

  function automatic void model_edge();
    bit pull, armed, auto_m, shoot, err;
    int nh;
    auto_m = (fire_mode == 2'b11);
    pull   = trigger && !m_prev_trig && (m_since_rst > 0);
    armed  = (mode_selector == 4'b0010) && !loading && (ammo_count != 0) &&
             !m_ovh && (fire_mode != 2'b00);
    shoot = 0; err = 0;
    if (m_next < 0) begin
      if (pull) begin
        if (armed) begin
          shoot  = 1;
          m_left = (fire_mode == 2'b10) ? BURST - 1 : 0;
        end else begin
          err = 1;
        end
      end
    end else if (edge_n == m_next) begin
      if (armed && (m_left > 0 || (auto_m && trigger))) begin
        shoot  = 1;
        m_left = auto_m ? 0 : m_left - 1;
      end else begin
        m_next = -1;
      end
    end
    if (shoot) begin
      m_next = edge_n + 1 + COOL;
      m_rate = auto_m ? RA : RS;
    end
    nh = m_fire ? ((m_heat + HPS > 255) ? 255 : m_heat + HPS)
                : ((m_heat > 0) ? m_heat - 1 : 0);
    if (m_heat >= HMAX)      m_ovh = 1;
    else if (m_heat <= HRES) m_ovh = 0;
    m_heat = nh;
    m_fire = shoot;
    m_err  = err;
    m_prev_trig = trigger;
    m_since_rst++;
    edge_n++;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("fire",      int'(fire),      int'(m_fire));
    chk("fire_rate", int'(fire_rate), m_rate);
    chk("error",     int'(error),     int'(m_err));
    chk("overheat",  int'(overheat),  int'(m_ovh));
    chk("heat",      int'(heat),      m_heat);
  endtask

  task automatic drive(input logic [3:0] ms, input logic [1:0] fm, input logic tr,
                       input logic ld, input logic [8:0] am);
    mode_selector = ms; fire_mode = fm; trigger = tr; loading = ld; ammo_count = am;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    step();
    step();
  endtask

  typedef struct {
    logic [3:0] ms;
    logic [1:0] fm;
    logic       ld;
    logic [8:0] ammo;
    logic       exp_fire;
    logic       exp_err;
    int         exp_rate;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, last, ovh_shots, n, cool_fires;
    int pos[3];
    bit done;

    vecs[0] = '{4'b0001, 2'b01, 1'b0, 9'd100, 1'b0, 1'b1, 0};
    vecs[1] = '{4'b0010, 2'b01, 1'b0, 9'd0,   1'b0, 1'b1, 0};
    vecs[2] = '{4'b0010, 2'b01, 1'b1, 9'd100, 1'b0, 1'b1, 0};
    vecs[3] = '{4'b0010, 2'b00, 1'b0, 9'd100, 1'b0, 1'b1, 0};
    vecs[4] = '{4'b0010, 2'b01, 1'b0, 9'd100, 1'b1, 1'b0, RS};
    vecs[5] = '{4'b0010, 2'b10, 1'b0, 9'd100, 1'b1, 1'b0, RS};
    vecs[6] = '{4'b0010, 2'b11, 1'b0, 9'd100, 1'b1, 1'b0, RA};
    vecs[7] = '{4'b1010, 2'b11, 1'b0, 9'd100, 1'b0, 1'b1, 0};
    vecs[8] = '{4'b0010, 2'b01, 1'b0, 9'd1,   1'b1, 1'b0, RS};
    vecs[9] = '{4'b0010, 2'b11, 1'b0, 9'd511, 1'b1, 1'b0, RA};

    // Reset values, checked before any clock edge.
    rst = 1'b1;
    drive(4'b0000, 2'b00, 1'b0, 1'b0, 9'd0);
    edge_n = 0;
    model_reset();
    #2;
    chk("reset fire",     int'(fire),      0);
    chk("reset rate",     int'(fire_rate), RS);
    chk("reset error",    int'(error),     0);
    chk("reset overheat", int'(overheat),  0);
    chk("reset heat",     int'(heat),      0);
    reset_dut();

    // Arming table: one fresh pull per vector.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ms, vecs[i].fm, 1'b0, vecs[i].ld, vecs[i].ammo);
      step();
      step();
      trigger = 1'b1;
      step();
      chk($sformatf("vec%0d fire", i), int'(fire), int'(vecs[i].exp_fire));
      chk($sformatf("vec%0d error", i), int'(error), int'(vecs[i].exp_err));
      if (vecs[i].exp_fire) chk($sformatf("vec%0d rate", i), int'(fire_rate), vecs[i].exp_rate);
      trigger = 1'b0;
      repeat (20) step();
    end

    // Single: trigger held 20 cycles gives one shot on the first cycle.
    reset_dut();
    drive(4'b0010, 2'b01, 1'b0, 1'b0, 9'd100);
    step();
    trigger = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) chk("T1 latency", int'(fire), 1);
      if (fire) pulses++;
    end
    chk("T1 pulses", pulses, 1);
    chk("T1 rate", int'(fire_rate), RS);

    // Burst: shots at cycles 1, 6, 11; a second pull mid-burst is ignored.
    trigger = 1'b0;
    fire_mode = 2'b10;
    repeat (3) step();
    trigger = 1'b1;
    pulses = 0;
    pos = '{-1, -1, -1};
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) trigger = 1'b0;
      if (i == 4) trigger = 1'b1;
      step();
      if (fire) begin
        if (pulses < 3) pos[pulses] = i;
        pulses++;
      end
    end
    chk("T2 pulses", pulses, 3);
    chk("T2 shot1 cycle", pos[0], 1);
    chk("T2 shot2 cycle", pos[1], 6);
    chk("T2 shot3 cycle", pos[2], 11);

    // Abort: loading after the first burst shot; pulls during the gap are
    // silent, a pull once the gap has run out reports an error.
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    chk("T5 first shot", int'(fire), 1);
    loading = 1'b1;
    trigger = 1'b0;
    step();
    step();
    trigger = 1'b1;
    step();
    chk("T5 pull in gap error", int'(error), 0);
    trigger = 1'b0;
    step();
    step();
    chk("T5 no continuation", int'(fire), 0);
    trigger = 1'b1;
    step();
    chk("T5 idle pull error", int'(error), 1);
    trigger = 1'b0;
    loading = 1'b0;
    repeat (3) step();

    // Auto with trigger held: heat peaks at 4k+4 after shot k, so it first
    // reaches 200 on shot 49; overheat then blocks the next gap exit.
    reset_dut();
    drive(4'b0010, 2'b11, 1'b0, 1'b0, 9'd500);
    step();
    trigger = 1'b1;
    pulses = 0; last = -1; ovh_shots = -1; n = 0; done = 0;
    while (!done && n < 600) begin
      step();
      n++;
      if (fire) begin
        pulses++;
        if (last >= 0) chk("T3 period", n - last, 1 + COOL);
        last = n;
        chk("T3 rate", int'(fire_rate), RA);
      end
      if (overheat) begin
        ovh_shots = pulses;
        done = 1;
      end
    end
    chk("T3 shots at overheat", ovh_shots, 49);
    n = 0; cool_fires = 0;
    while (overheat && n < 300) begin
      step();
      n++;
      if (fire) cool_fires++;
    end
    chk("T3 overheat cleared", int'(overheat), 0);
    chk("T3 lockout cycles", n, 100);
    chk("T3 no fire while hot", cool_fires, 0);
    chk("T3 heat at clear", int'(heat), 99);
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    chk("T3 fire after cooling", int'(fire), 1);
    trigger = 1'b0;
    repeat (8) step();

    // Reset mid-burst (during the second shot's strobe) clears outputs at once;
    // a trigger held through reset does not fire until released and pulled.
    reset_dut();
    drive(4'b0010, 2'b10, 1'b0, 1'b0, 9'd100);
    step();
    trigger = 1'b1;
    repeat (6) step();
    chk("T6 second shot", int'(fire), 1);
    rst = 1'b1;
    #1;
    chk("T6 async fire",     int'(fire),      0);
    chk("T6 async error",    int'(error),     0);
    chk("T6 async heat",     int'(heat),      0);
    chk("T6 async overheat", int'(overheat),  0);
    chk("T6 async rate",     int'(fire_rate), RS);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (fire) pulses++;
    end
    chk("T6 held trigger no shot", pulses, 0);
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    chk("T6 fresh pull fires", int'(fire), 1);
    trigger = 1'b0;
    repeat (16) step();

    // Randomised traffic against the model.
    reset_dut();
    drive(4'b0010, 2'b01, 1'b0, 1'b0, 9'd100);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, (fire_mode == 2'b11) ? 11 : 3) == 0) trigger = ~trigger;
      if ($urandom_range(0, 39) == 0) fire_mode = 2'($urandom_range(0, 3));
      mode_selector = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
      loading = ($urandom_range(0, 15) == 0);
      ammo_count = ($urandom_range(0, 15) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
